imm_ext_pipe: RTL and testbench

Parametrised, registered immediate-extension stage for the multi-cycle datapath. Accepts an IN_W-bit immediate plus a 2-bit mode, produces an OUT_W-bit value using sign extend, zero extend, upper placement or sign-extend-and-shift-left-2. Results enter a DEPTH-entry output buffer behind a valid/ready handshake, so the control FSM can issue extends ahead of the ALU-source mux consuming them. Sits between instruction-register decode and the ALU B-input mux.

---
 rtl/imm_ext_pkg.sv | 16 +
 rtl/imm_ext_pipe_fifo.sv | 99 +++++++++
 rtl/imm_ext_pipe.sv | 60 ++++++
 tb/tb_imm_ext_pipe.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension stage: extension mode codes
// (also used by the main control decoder) and the output buffer state type.
package imm_ext_pkg;

  localparam logic [1:0] EXT_SEXT   = 2'b00;
  localparam logic [1:0] EXT_ZEXT   = 2'b01;
  localparam logic [1:0] EXT_UPPER  = 2'b10;
  localparam logic [1:0] EXT_BRANCH = 2'b11;

  typedef enum logic [1:0] {
    FIFO_EMPTY   = 2'b00,
    FIFO_PARTIAL = 2'b01,
    FIFO_FULL    = 2'b10
  } fifo_state_e;

endpackage

// File: rtl/imm_ext_pipe_fifo.sv
// Circular output buffer for extended immediates; in_ready and out_valid come
// straight from the registered EMPTY/PARTIAL/FULL state.
module ext_fifo
  import imm_ext_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] out_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] ALMOST_CNT = CNT_W'(DEPTH - 1);

  fifo_state_e      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push;
  logic             pop;

  assign in_ready  = (state_q != FIFO_FULL);
  assign out_valid = (state_q != FIFO_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_count = count_q;
  // Once drained, keep presenting the last popped value rather than a stale slot.
  assign out_data  = out_valid ? mem_q[head_q] : last_q;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    last_d  = last_q;
    count_d = count_q;
    state_d = state_q;

    if (push) begin
      mem_d[tail_q] = in_data;
      tail_d        = (tail_q == LAST_PTR) ? '0 : tail_q + PTR_W'(1);
    end
    if (pop) begin
      last_d = mem_q[head_q];
      head_d = (head_q == LAST_PTR) ? '0 : head_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      FIFO_EMPTY: begin
        if (push) state_d = (DEPTH == 1) ? FIFO_FULL : FIFO_PARTIAL;
      end
      FIFO_PARTIAL: begin
        if (push && !pop && count_q == ALMOST_CNT) state_d = FIFO_FULL;
        else if (pop && !push && count_q == CNT_W'(1)) state_d = FIFO_EMPTY;
      end
      FIFO_FULL: begin
        if (pop && !push) state_d = (DEPTH == 1) ? FIFO_EMPTY : FIFO_PARTIAL;
      end
      default: state_d = FIFO_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FIFO_EMPTY;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      last_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      last_q  <= last_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate-extension stage: extends the decoded immediate by mode
// and queues the result for the ALU B-input mux.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W-1:0]            in_imm,
  input  logic [1:0]                 in_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] out_count
);

  if (OUT_W < IN_W + 2) begin : g_bad_width
    $error("imm_ext_pipe: OUT_W must be at least IN_W + 2");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("imm_ext_pipe: DEPTH must be at least 1");
  end

  logic [OUT_W-1:0] sext_value;
  logic [OUT_W-1:0] ext_value;

  // Branch mode reuses the sign-extended value as a word offset.
  always_comb begin
    sext_value = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
    ext_value  = sext_value;
    case (in_mode)
      EXT_SEXT:   ext_value = sext_value;
      EXT_ZEXT:   ext_value = {{(OUT_W-IN_W){1'b0}}, in_imm};
      EXT_UPPER:  ext_value = {in_imm, {(OUT_W-IN_W){1'b0}}};
      EXT_BRANCH: ext_value = {sext_value[OUT_W-3:0], 2'b00};
      default:    ext_value = sext_value;
    endcase
  end

  ext_fifo #(
    .WIDTH(OUT_W),
    .DEPTH(DEPTH)
  ) u_ext_fifo (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (ext_value),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_count(out_count)
  );

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: directed handshake/reset scenarios
// followed by random traffic against a queue-based reference model.
module tb_imm_ext_pipe;

  localparam int IN_W  = 16;
  localparam int OUT_W = 32;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_count;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] modelQueue[$];
  logic [31:0] lastPopped = 32'h0;

  imm_ext_pipe #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_imm   (in_imm),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  // Reference extension written as plain integer arithmetic.
  function automatic logic [31:0] modelExtend(input logic [15:0] imm, input logic [1:0] mode);
    logic [31:0] signedValue;
    logic [31:0] result;
    signedValue = (imm >= 16'h8000) ? 32'(imm) - 32'h0001_0000 : 32'(imm);
    case (mode)
      2'd0:    result = signedValue;
      2'd1:    result = 32'(imm);
      2'd2:    result = 32'(imm) * 32'h0001_0000;
      default: result = signedValue * 32'd4;
    endcase
    return result;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
    vectors++;
    if (got !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, expected, $time);
    end
  endtask

  // Drives one cycle, advances the model, then checks all outputs after the edge.
  task automatic applyStimulus(input logic rst, input logic iv, input logic [15:0] imm,
                               input logic [1:0] mode, input logic ordy);
    bit doPush;
    bit doPop;
    @(negedge clk);
    reset     = rst;
    in_valid  = iv;
    in_imm    = imm;
    in_mode   = mode;
    out_ready = ordy;
    if (rst) begin
      modelQueue.delete();
      lastPopped = 32'h0;
    end else begin
      doPush = iv && (modelQueue.size() < DEPTH);
      doPop  = ordy && (modelQueue.size() > 0);
      if (doPop) lastPopped = modelQueue.pop_front();
      if (doPush) modelQueue.push_back(modelExtend(imm, mode));
    end
    @(posedge clk);
    #1;
    checkOutput("out_valid", 32'(out_valid), 32'(modelQueue.size() != 0));
    checkOutput("out_count", 32'(out_count), 32'(modelQueue.size()));
    checkOutput("in_ready",  32'(in_ready),  32'(modelQueue.size() < DEPTH));
    checkOutput("out_data",  out_data, (modelQueue.size() != 0) ? modelQueue[0] : lastPopped);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_imm    = 16'h0;
    in_mode   = 2'b00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);

    applyStimulus(1'b0, 1'b0, 16'h0, 2'b00, 1'b1);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_count", 32'(out_count), 32'd0);
    checkOutput("rst_ready", 32'(in_ready),  32'd1);
    checkOutput("rst_data",  out_data,       32'h0);

    applyStimulus(1'b0, 1'b1, 16'h8004, 2'b00, 1'b1);
    checkOutput("sext_data",  out_data, 32'hFFFF_8004);
    checkOutput("sext_valid", 32'(out_valid), 32'd1);
    applyStimulus(1'b0, 1'b1, 16'h8004, 2'b01, 1'b1);
    checkOutput("zext_data", out_data, 32'h0000_8004);
    applyStimulus(1'b0, 1'b1, 16'h8004, 2'b10, 1'b1);
    checkOutput("upper_data", out_data, 32'h8004_0000);
    applyStimulus(1'b0, 1'b1, 16'h8004, 2'b11, 1'b1);
    checkOutput("branch_data", out_data, 32'hFFFE_0010);
    applyStimulus(1'b0, 1'b0, 16'h0, 2'b00, 1'b1);
    checkOutput("drain_valid", 32'(out_valid), 32'd0);
    checkOutput("drain_hold",  out_data, 32'hFFFE_0010);

    applyStimulus(1'b0, 1'b1, 16'h1111, 2'b01, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h2222, 2'b01, 1'b0);
    checkOutput("full_ready", 32'(in_ready),  32'd0);
    checkOutput("full_count", 32'(out_count), 32'd2);
    applyStimulus(1'b0, 1'b1, 16'h3333, 2'b01, 1'b0);
    checkOutput("held_count", 32'(out_count), 32'd2);
    checkOutput("held_head",  out_data, 32'h0000_1111);
    applyStimulus(1'b0, 1'b1, 16'h3333, 2'b01, 1'b1);
    checkOutput("pop_only_count", 32'(out_count), 32'd1);
    checkOutput("pop_only_head",  out_data, 32'h0000_2222);
    applyStimulus(1'b0, 1'b1, 16'h3333, 2'b01, 1'b1);
    checkOutput("pushpop_count", 32'(out_count), 32'd1);
    checkOutput("pushpop_head",  out_data, 32'h0000_3333);
    applyStimulus(1'b0, 1'b1, 16'h4444, 2'b01, 1'b0);
    checkOutput("refill_count", 32'(out_count), 32'd2);

    applyStimulus(1'b1, 1'b1, 16'h5555, 2'b01, 1'b1);
    checkOutput("midrst_count", 32'(out_count), 32'd0);
    checkOutput("midrst_data",  out_data, 32'h0);
    checkOutput("midrst_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b0, 1'b0, 16'h0, 2'b00, 1'b1);
    checkOutput("postrst_valid", 32'(out_valid), 32'd0);
    checkOutput("postrst_data",  out_data, 32'h0);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b0, 1'b1, 16'($urandom), 2'($urandom_range(0, 3)), 1'b1);
      checkOutput("wrap_no_stall", 32'(in_ready), 32'd1);
    end

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                    16'($urandom), 2'($urandom_range(0, 3)), ($urandom_range(0, 2) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
